// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES-128 round-key constants and key-store state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;
  localparam int KEY_W          = 128;
  localparam int NUM_ROUND_KEYS = 11;
  localparam int ADDR_W         = 4;
  localparam int KEY_ADDR_FIRST = 1;
  localparam int KEY_ADDR_LAST  = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } store_state_t;
endpackage

`default_nettype wire

// File: rtl/round_key_ram.sv
// ============================================================================
// Module  : round_key_ram
// Brief   : Round-key array, one synchronous write port, one registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module round_key_ram #(
  parameter int KEY_W  = aes_pkg::KEY_W,
  parameter int DEPTH  = aes_pkg::NUM_ROUND_KEYS,
  parameter int ADDR_W = aes_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rdata
);
  logic [KEY_W-1:0] mem [DEPTH];

  // Read and write share one edge, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

`default_nettype wire

// File: rtl/round_key_store.sv
// ============================================================================
// Module  : round_key_store
// Brief   : Captures 11 AES-128 round keys; serves random reads and bursts.
//           Optional reverse-order access: ROUND_KEY_STORE_DECRYPT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module round_key_store #(
  parameter int KEY_W    = aes_pkg::KEY_W,
  parameter int NUM_KEYS = aes_pkg::NUM_ROUND_KEYS,
  parameter int ADDR_W   = aes_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [ADDR_W-1:0] key_addr,
  input  logic              key_loaded,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_round,
  input  logic              stream_start,
`ifdef ROUND_KEY_STORE_DECRYPT_EN
  input  logic              rd_decrypt,
`endif
  output logic              rd_valid,
  output logic [KEY_W-1:0]  rd_key,
  output logic [ADDR_W-1:0] rd_index,
  output logic              rd_last,
  output logic              rd_err,
  output logic              busy,
  output logic              keys_ready
);
  import aes_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_KEYS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LO  = ADDR_W'(KEY_ADDR_FIRST);
  localparam logic [ADDR_W-1:0] ADDR_HI  = ADDR_W'(KEY_ADDR_LAST);

  store_state_t      state;
  logic [NUM_KEYS-1:0] valid;
  logic [ADDR_W-1:0] cnt;
  logic              dir;
  logic              zero_key;
  logic              decrypt;
  logic              wr_hit, ram_we, ram_re, rd_in_range, rd_bad, abort;
  logic [ADDR_W-1:0] wr_slot, rd_slot, stream_slot, start_slot, ram_raddr;
  logic [KEY_W-1:0]  ram_q;

`ifdef ROUND_KEY_STORE_DECRYPT_EN
  assign decrypt = rd_decrypt;
`else
  assign decrypt = 1'b0;
`endif

  assign wr_hit      = (key_addr >= ADDR_LO) && (key_addr <= ADDR_HI);
  assign wr_slot     = key_addr - ADDR_LO;
  assign ram_we      = wr_hit && !clear;
  assign abort       = wr_hit || clear;
  assign rd_in_range = (rd_round <= LAST_IDX);
  assign rd_slot     = decrypt ? (LAST_IDX - rd_round) : rd_round;
  assign rd_bad      = !rd_in_range || !valid[rd_slot];
  assign stream_slot = dir ? (LAST_IDX - cnt) : cnt;
  assign start_slot  = decrypt ? LAST_IDX : '0;

  // Error beats and reset force the key to zero without touching the array.
  assign rd_key = zero_key ? '0 : ram_q;

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = '0;
    if (state == IDLE) begin
      if (stream_start) begin
        ram_re    = keys_ready;
        ram_raddr = start_slot;
      end else if (rd_req && rd_in_range) begin
        ram_re    = 1'b1;
        ram_raddr = rd_slot;
      end
    end else if (!abort && cnt <= LAST_IDX) begin
      ram_re    = 1'b1;
      ram_raddr = stream_slot;
    end
  end

  round_key_ram #(
    .KEY_W  (KEY_W),
    .DEPTH  (NUM_KEYS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_slot),
    .wdata (key_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
      zero_key   <= 1'b1;
      rd_valid   <= 1'b0;
      rd_index   <= '0;
      rd_last    <= 1'b0;
      rd_err     <= 1'b0;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_last    <= 1'b0;
      keys_ready <= (&valid) & key_loaded;

      if (clear)       valid <= '0;
      else if (wr_hit) valid[wr_slot] <= 1'b1;

      case (state)
        IDLE: begin
          if (stream_start) begin
            rd_valid <= 1'b1;
            if (keys_ready) begin
              state    <= STREAM;
              busy     <= 1'b1;
              cnt      <= ADDR_W'(1);
              dir      <= decrypt;
              rd_index <= start_slot;
              zero_key <= 1'b0;
            end else begin
              rd_err   <= 1'b1;
              rd_index <= '0;
              zero_key <= 1'b1;
            end
          end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_err   <= rd_bad;
            zero_key <= rd_bad;
            rd_index <= rd_in_range ? rd_slot : rd_round;
          end
        end
        STREAM: begin
          // cnt past the last slot is the idle cycle trailing the final beat.
          if (abort || cnt > LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rd_valid <= 1'b1;
            rd_index <= stream_slot;
            zero_key <= 1'b0;
            rd_last  <= (cnt == LAST_IDX);
            cnt      <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_round_key_store.sv
// ============================================================================
// Module  : tb_round_key_store
// Brief   : Self-checking bench for round_key_store against a slot-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_key_store;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_in = '0;
  logic [3:0]   key_addr = '0;
  logic         key_loaded = 1'b0;
  logic         clear = 1'b0;
  logic         rd_req = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         stream_start = 1'b0;
`ifdef ROUND_KEY_STORE_DECRYPT_EN
  logic         rd_decrypt = 1'b0;
`endif
  logic         rd_valid;
  logic [127:0] rd_key;
  logic [3:0]   rd_index;
  logic         rd_last;
  logic         rd_err;
  logic         busy;
  logic         keys_ready;

  int compared = 0;
  int mismatched = 0;

  logic [127:0] fips    [11];
  logic [127:0] keys_m  [11];
  bit           valid_m [11];

  round_key_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_addr     (key_addr),
    .key_loaded   (key_loaded),
    .clear        (clear),
    .rd_req       (rd_req),
    .rd_round     (rd_round),
    .stream_start (stream_start),
`ifdef ROUND_KEY_STORE_DECRYPT_EN
    .rd_decrypt   (rd_decrypt),
`endif
    .rd_valid     (rd_valid),
    .rd_key       (rd_key),
    .rd_index     (rd_index),
    .rd_last      (rd_last),
    .rd_err       (rd_err),
    .busy         (busy),
    .keys_ready   (keys_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_reset();
    check("rst_rd_valid", 128'(rd_valid), 128'd0);
    check("rst_rd_key", rd_key, 128'd0);
    check("rst_rd_index", 128'(rd_index), 128'd0);
    check("rst_rd_last", 128'(rd_last), 128'd0);
    check("rst_rd_err", 128'(rd_err), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_keys_ready", 128'(keys_ready), 128'd0);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [3:0]   rr, wa;
    logic [127:0] wd, exp_key;
    bit           exp_err;
    int           sel;

    fips = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    for (int i = 0; i < 11; i++) begin
      keys_m[i]  = '0;
      valid_m[i] = 1'b0;
    end

    // Reset state
    #2 rst_n = 1'b0;
    #2 check_quiet_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("ready_after_reset", 128'(keys_ready), 128'd0);

    // Load FIPS-197 schedule
    key_loaded = 1'b1;
    for (int i = 0; i < 11; i++) begin
      key_addr = 4'(i + 1);
      key_in   = fips[i];
      step();
      keys_m[i]  = fips[i];
      valid_m[i] = 1'b1;
    end
    key_addr = '0;
    check("ready_on_last_write", 128'(keys_ready), 128'd0);
    step();
    check("ready_after_load", 128'(keys_ready), 128'd1);

    // Random read of round 1
    rd_req = 1'b1; rd_round = 4'd1;
    step();
    rd_req = 1'b0;
    check("rd1_valid", 128'(rd_valid), 128'd1);
    check("rd1_key", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    check("rd1_index", 128'(rd_index), 128'd1);
    check("rd1_err", 128'(rd_err), 128'd0);
    step();
    check("rd1_pulse", 128'(rd_valid), 128'd0);
    check("rd1_hold", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

    // keys_ready follows key_loaded
    key_loaded = 1'b0;
    step();
    check("ready_loaded_low", 128'(keys_ready), 128'd0);
    key_loaded = 1'b1;
    step();
    check("ready_loaded_high", 128'(keys_ready), 128'd1);

    // Full stream; rd_req and stream_start mid-burst are ignored
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("st_valid%0d", k), 128'(rd_valid), 128'd1);
      check($sformatf("st_index%0d", k), 128'(rd_index), 128'(k));
      check($sformatf("st_key%0d", k), rd_key, fips[k]);
      check($sformatf("st_err%0d", k), 128'(rd_err), 128'd0);
      check($sformatf("st_last%0d", k), 128'(rd_last), 128'(k == 10));
      check($sformatf("st_busy%0d", k), 128'(busy), 128'd1);
      rd_req       = (k == 3);
      rd_round     = 4'd2;
      stream_start = (k == 3);
      step();
    end
    rd_req = 1'b0; stream_start = 1'b0;
    check("st_end_busy", 128'(busy), 128'd0);
    check("st_end_valid", 128'(rd_valid), 128'd0);
    check("st_end_last", 128'(rd_last), 128'd0);

    // Out-of-range read
    rd_req = 1'b1; rd_round = 4'd12;
    step();
    rd_req = 1'b0;
    check("oor_valid", 128'(rd_valid), 128'd1);
    check("oor_err", 128'(rd_err), 128'd1);
    check("oor_key", rd_key, 128'd0);
    check("oor_index", 128'(rd_index), 128'd12);

    // Clear at beat 4 aborts the stream
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ab_index%0d", k), 128'(rd_index), 128'(k));
      check($sformatf("ab_key%0d", k), rd_key, fips[k]);
      if (k < 4) step();
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 11; i++) valid_m[i] = 1'b0;
    check("ab_valid", 128'(rd_valid), 128'd0);
    check("ab_last", 128'(rd_last), 128'd0);
    check("ab_busy", 128'(busy), 128'd0);
    step();
    check("ab_valid2", 128'(rd_valid), 128'd0);
    check("ab_ready", 128'(keys_ready), 128'd0);

    rd_req = 1'b1; rd_round = 4'd3;
    step();
    rd_req = 1'b0;
    check("clr_rd_valid", 128'(rd_valid), 128'd1);
    check("clr_rd_err", 128'(rd_err), 128'd1);
    check("clr_rd_key", rd_key, 128'd0);

    // Only slots 0..9 valid: stream_start gives one error beat
    for (int i = 0; i < 10; i++) begin
      key_addr = 4'(i + 1);
      key_in   = rand_key();
      step();
      keys_m[i]  = key_in;
      valid_m[i] = 1'b1;
    end
    key_addr = '0;
    step();
    step();
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    check("nr_valid", 128'(rd_valid), 128'd1);
    check("nr_err", 128'(rd_err), 128'd1);
    check("nr_index", 128'(rd_index), 128'd0);
    check("nr_key", rd_key, 128'd0);
    check("nr_busy", 128'(busy), 128'd0);
    step();
    check("nr_valid2", 128'(rd_valid), 128'd0);
    check("nr_busy2", 128'(busy), 128'd0);

    // Randomized reads with concurrent writes against the slot model
    for (int n = 0; n < 30; n++) begin
      rr  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 2);
      wa  = (sel == 0) ? rr + 4'd1 : (sel == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      wd  = rand_key();
      exp_err = (rr > 4'd10) ? 1'b1 : !valid_m[rr];
      exp_key = exp_err ? 128'd0 : keys_m[rr];
      rd_req = 1'b1; rd_round = rr; key_addr = wa; key_in = wd;
      step();
      rd_req = 1'b0; key_addr = '0;
      check($sformatf("rnd%0d_valid", n), 128'(rd_valid), 128'd1);
      check($sformatf("rnd%0d_index", n), 128'(rd_index), 128'(rr));
      check($sformatf("rnd%0d_err", n), 128'(rd_err), 128'(exp_err));
      check($sformatf("rnd%0d_key", n), rd_key, exp_key);
      if (wa >= 4'd1 && wa <= 4'd11) begin
        keys_m[wa - 4'd1]  = wd;
        valid_m[wa - 4'd1] = 1'b1;
      end
      step();
      check($sformatf("rnd%0d_pulse", n), 128'(rd_valid), 128'd0);
      check($sformatf("rnd%0d_hold", n), rd_key, exp_key);
    end

    // Random contents, stream, asynchronous reset at beat 6
    for (int i = 0; i < 11; i++) begin
      key_addr = 4'(i + 1);
      key_in   = rand_key();
      step();
      keys_m[i]  = key_in;
      valid_m[i] = 1'b1;
    end
    key_addr = '0;
    step();
    step();
    check("rs_ready", 128'(keys_ready), 128'd1);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("rs_index%0d", k), 128'(rd_index), 128'(k));
      check($sformatf("rs_key%0d", k), rd_key, keys_m[k]);
      if (k < 6) step();
    end
    #2 rst_n = 1'b0;
    #1 check_quiet_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) valid_m[i] = 1'b0;
    step();
    step();
    check("post_rst_ready", 128'(keys_ready), 128'd0);
    check("post_rst_busy", 128'(busy), 128'd0);
    check("post_rst_valid", 128'(rd_valid), 128'd0);
    rd_req = 1'b1; rd_round = 4'd0;
    step();
    rd_req = 1'b0;
    check("post_rst_rd_err", 128'(rd_err), 128'(!valid_m[0]));
    check("post_rst_rd_key", rd_key, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

`default_nettype wire
